// File: rtl/btb_pkg.sv
// Shared constants and helpers for the branch target buffer.
package btb_pkg;

    // Ceiling log2, used to size the replacement pointer.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Counter encodings for a w-bit direction counter.
    function automatic int unsigned cnt_weak_nt(input int unsigned w);
        return (32'd1 << (w - 1)) - 1;
    endfunction

    function automatic int unsigned cnt_weak_t(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

    function automatic int unsigned cnt_max(input int unsigned w);
        return (32'd1 << w) - 1;
    endfunction

    localparam int unsigned CNT_W_DEFAULT = 2;
    localparam int unsigned CNT_WEAK_NT   = cnt_weak_nt(CNT_W_DEFAULT);
    localparam int unsigned CNT_WEAK_T    = cnt_weak_t(CNT_W_DEFAULT);
    localparam int unsigned CNT_MAX       = cnt_max(CNT_W_DEFAULT);

    // Sequential PC; callers truncate to their width so the sum wraps.
    function automatic logic [63:0] next_seq_pc(input logic [63:0] pc);
        return pc + 64'd1;
    endfunction

endpackage

// File: rtl/btb_predictor_if.sv
// Lookup, resolve and status signals between the pipeline and the BTB.
interface btb_predictor_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned PERF_W = 16
);
    logic [ADDR_W-1:0] cur_pc;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_pc;
    logic              resolve_valid;
    logic [ADDR_W-1:0] resolve_pc;
    logic              resolve_taken;
    logic [ADDR_W-1:0] resolve_target;
    logic              resolve_pred_taken;
    logic [ADDR_W-1:0] resolve_pred_pc;
    logic              mispredict;
    logic [ADDR_W-1:0] redirect_pc;
    logic              flush_all;
    logic [PERF_W-1:0] mispredict_count;

    // Pipeline side.
    modport master (
        output cur_pc, resolve_valid, resolve_pc, resolve_taken, resolve_target,
               resolve_pred_taken, resolve_pred_pc, flush_all,
        input  pred_taken, pred_pc, mispredict, redirect_pc, mispredict_count
    );

    // Predictor side.
    modport slave (
        input  cur_pc, resolve_valid, resolve_pc, resolve_taken, resolve_target,
               resolve_pred_taken, resolve_pred_pc, flush_all,
        output pred_taken, pred_pc, mispredict, redirect_pc, mispredict_count
    );
endinterface

// File: rtl/btb_sat_ctr.sv
// Saturating up/down direction counter with parallel load; exposes its MSB.
module btb_sat_ctr
    import btb_pkg::*;
#(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             inc,
    input  logic             dec,
    output logic             taken
);
    localparam logic [CNT_W-1:0] RstVal = CNT_W'(cnt_weak_nt(CNT_W));
    localparam logic [CNT_W-1:0] MaxVal = CNT_W'(cnt_max(CNT_W));

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: load wins, otherwise step and clamp at both ends.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (inc && cnt_q != MaxVal) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register, reset to weakly not-taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= RstVal;
        else      cnt_q <= cnt_d;
    end

    assign taken = cnt_q[CNT_W-1];
endmodule

// File: rtl/btb_predictor.sv
// Fully associative BTB: same-cycle lookup, EXE-stage training, mispredict detect.
module btb_predictor
    import btb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned ENTRIES = 8,
    parameter int unsigned CNT_W   = 2,
    parameter int unsigned PERF_W  = 16
) (
    input logic            clk,
    input logic            rst,
    btb_predictor_if.slave bus
);
    localparam int unsigned PTR_W = clog2(ENTRIES);
    typedef logic [ADDR_W-1:0] addr_t;

    logic [ENTRIES-1:0] valid_q, valid_d;
    addr_t              tag_q [ENTRIES];
    addr_t              tag_d [ENTRIES];
    addr_t              tgt_q [ENTRIES];
    addr_t              tgt_d [ENTRIES];
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PERF_W-1:0]  perf_q, perf_d;

    logic [ENTRIES-1:0] ctr_taken, ctr_load, ctr_inc, ctr_dec;

    logic             lk_hit, lk_msb;
    addr_t            lk_tgt, lk_seq, rs_seq;
    logic             rs_hit, has_free;
    logic [PTR_W-1:0] rs_idx, free_idx, victim;

    // Per-entry direction counters.
    for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
        btb_sat_ctr #(.CNT_W(CNT_W)) u_ctr (
            .clk      (clk),
            .rst      (rst),
            .load     (ctr_load[g]),
            .load_val (CNT_W'(cnt_weak_t(CNT_W))),
            .inc      (ctr_inc[g]),
            .dec      (ctr_dec[g]),
            .taken    (ctr_taken[g])
        );
    end

    // CAM match for lookup and resolve, plus free-slot search; descending so lowest index wins.
    always_comb begin
        lk_hit   = 1'b0;
        lk_msb   = 1'b0;
        lk_tgt   = '0;
        rs_hit   = 1'b0;
        rs_idx   = '0;
        has_free = 1'b0;
        free_idx = '0;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (valid_q[i] && tag_q[i] == bus.cur_pc) begin
                lk_hit = 1'b1;
                lk_msb = ctr_taken[i];
                lk_tgt = tgt_q[i];
            end
            if (valid_q[i] && tag_q[i] == bus.resolve_pc) begin
                rs_hit = 1'b1;
                rs_idx = PTR_W'(i);
            end
            if (!valid_q[i]) begin
                has_free = 1'b1;
                free_idx = PTR_W'(i);
            end
        end
    end

    assign victim = has_free ? free_idx : ptr_q;
    assign lk_seq = ADDR_W'(next_seq_pc(64'(bus.cur_pc)));
    assign rs_seq = ADDR_W'(next_seq_pc(64'(bus.resolve_pc)));

    assign bus.pred_taken  = lk_hit & lk_msb;
    assign bus.pred_pc     = (lk_hit & lk_msb) ? lk_tgt : lk_seq;
    assign bus.mispredict  = bus.resolve_valid &
                             ((bus.resolve_taken != bus.resolve_pred_taken) |
                              (bus.resolve_taken & (bus.resolve_target != bus.resolve_pred_pc)));
    assign bus.redirect_pc = bus.resolve_taken ? bus.resolve_target : rs_seq;
    assign bus.mispredict_count = perf_q;

    // Training / allocation / flush next-state; flush overrides training.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        tgt_d    = tgt_q;
        ptr_d    = ptr_q;
        ctr_load = '0;
        ctr_inc  = '0;
        ctr_dec  = '0;
        if (bus.flush_all) begin
            valid_d = '0;
            ptr_d   = '0;
        end else if (bus.resolve_valid) begin
            if (rs_hit) begin
                if (bus.resolve_taken) begin
                    ctr_inc[rs_idx] = 1'b1;
                    tgt_d[rs_idx]   = bus.resolve_target;
                end else begin
                    ctr_dec[rs_idx] = 1'b1;
                end
            end else if (bus.resolve_taken) begin
                valid_d[victim]  = 1'b1;
                tag_d[victim]    = bus.resolve_pc;
                tgt_d[victim]    = bus.resolve_target;
                ctr_load[victim] = 1'b1;
                // Only a real eviction moves the round-robin pointer.
                if (!has_free) ptr_d = ptr_q + PTR_W'(1);
            end
        end
    end

    // Saturating mispredict counter; survives flush_all.
    always_comb begin
        perf_d = perf_q;
        if (bus.mispredict && perf_q != '1) perf_d = perf_q + PERF_W'(1);
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            ptr_q   <= '0;
            perf_q  <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            perf_q  <= perf_d;
            tag_q   <= tag_d;
            tgt_q   <= tgt_d;
        end
    end
endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench for btb_predictor (ENTRIES = 8, CNT_W = 2, PERF_W = 4).
module tb_btb_predictor;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_cnt  = 0;

    btb_predictor_if #(.ADDR_W(16), .PERF_W(4)) bus ();

    btb_predictor #(
        .ADDR_W  (16),
        .ENTRIES (8),
        .CNT_W   (2),
        .PERF_W  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic resolve(input logic [15:0] pc, input logic t, input logic [15:0] tgt,
                           input logic pt, input logic [15:0] ppc);
        bus.resolve_valid      = 1'b1;
        bus.resolve_pc         = pc;
        bus.resolve_taken      = t;
        bus.resolve_target     = tgt;
        bus.resolve_pred_taken = pt;
        bus.resolve_pred_pc    = ppc;
        #1;
    endtask

    // One clock edge; expected perf count follows the driven resolve fields.
    task automatic tick();
        if (bus.resolve_valid && ((bus.resolve_taken != bus.resolve_pred_taken) ||
            (bus.resolve_taken && bus.resolve_target != bus.resolve_pred_pc)))
            if (exp_cnt < 15) exp_cnt++;
        @(posedge clk);
        @(negedge clk);
        bus.resolve_valid = 1'b0;
        bus.flush_all     = 1'b0;
        #1;
    endtask

    task automatic look(input string tag, input logic [15:0] pc, input logic t,
                        input logic [15:0] npc);
        bus.cur_pc = pc;
        #1;
        check({tag, "_taken"}, 32'(bus.pred_taken), 32'(t));
        check({tag, "_pc"}, 32'(bus.pred_pc), 32'(npc));
    endtask

    initial begin
        bus.cur_pc = 16'h0040;
        bus.resolve_valid = 1'b0;
        bus.resolve_pc = '0;
        bus.resolve_taken = 1'b0;
        bus.resolve_target = '0;
        bus.resolve_pred_taken = 1'b0;
        bus.resolve_pred_pc = '0;
        bus.flush_all = 1'b0;
        #1;
        // Reset state, before any clock edge.
        look("rst0", 16'h0040, 1'b0, 16'h0041);
        check("rst0_cnt", 32'(bus.mispredict_count), 0);
        check("idle_mis", 32'(bus.mispredict), 0);
        @(negedge clk);
        rst = 1'b1;
        #1;

        // Cold branch.
        resolve(16'h0010, 1'b1, 16'h0030, 1'b0, 16'h0011);
        check("cold_mis", 32'(bus.mispredict), 1);
        check("cold_redir", 32'(bus.redirect_pc), 32'h0030);
        tick();
        look("cold_hit", 16'h0010, 1'b1, 16'h0030);
        check("cold_cnt", 32'(bus.mispredict_count), 1);

        // Asynchronous reset mid-run with a valid entry.
        rst = 1'b0;
        #1;
        exp_cnt = 0;
        look("rst1_hit", 16'h0010, 1'b0, 16'h0011);
        look("rst1", 16'h0040, 1'b0, 16'h0041);
        check("rst1_cnt", 32'(bus.mispredict_count), 0);
        #1;
        rst = 1'b1;
        #1;

        // Counter hysteresis: alloc at 2, NT -> 1, T -> 2, T -> 3, NT -> 2.
        resolve(16'h0010, 1'b1, 16'h0030, 1'b0, 16'h0011);
        tick();
        look("hy_alloc", 16'h0010, 1'b1, 16'h0030);
        resolve(16'h0010, 1'b0, 16'h0000, 1'b1, 16'h0030);
        check("hy_nt_mis", 32'(bus.mispredict), 1);
        check("hy_nt_redir", 32'(bus.redirect_pc), 32'h0011);
        tick();
        look("hy_c1", 16'h0010, 1'b0, 16'h0011);
        resolve(16'h0010, 1'b1, 16'h0030, 1'b0, 16'h0011);
        tick();
        look("hy_c2", 16'h0010, 1'b1, 16'h0030);
        resolve(16'h0010, 1'b1, 16'h0030, 1'b1, 16'h0030);
        check("hy_ok_mis", 32'(bus.mispredict), 0);
        tick();
        resolve(16'h0010, 1'b0, 16'h0000, 1'b1, 16'h0030);
        tick();
        look("hy_c2b", 16'h0010, 1'b1, 16'h0030);
        check("hy_cnt", 32'(bus.mispredict_count), 32'(exp_cnt));

        // Target change on a correctly predicted direction.
        resolve(16'h0010, 1'b1, 16'h0050, 1'b1, 16'h0030);
        check("tc_mis", 32'(bus.mispredict), 1);
        check("tc_redir", 32'(bus.redirect_pc), 32'h0050);
        // Lookup in the same cycle still sees the old target.
        look("tc_nobyp", 16'h0010, 1'b1, 16'h0030);
        tick();
        look("tc_new", 16'h0010, 1'b1, 16'h0050);

        // Flush, then fill all eight entries.
        bus.flush_all = 1'b1;
        tick();
        look("fl_miss", 16'h0010, 1'b0, 16'h0011);
        for (int i = 0; i < 8; i++) begin
            resolve(16'h0100 + 16'(i), 1'b1, 16'h1000 + 16'(i), 1'b0, 16'h0000);
            tick();
        end
        look("rp_e7", 16'h0107, 1'b1, 16'h1007);
        resolve(16'h0200, 1'b1, 16'h2000, 1'b0, 16'h0000);
        tick();
        look("rp_ev0", 16'h0100, 1'b0, 16'h0101);
        look("rp_keep1", 16'h0101, 1'b1, 16'h1001);
        look("rp_new0", 16'h0200, 1'b1, 16'h2000);
        resolve(16'h0201, 1'b1, 16'h2001, 1'b0, 16'h0000);
        tick();
        look("rp_ev1", 16'h0101, 1'b0, 16'h0102);
        look("rp_keep2", 16'h0102, 1'b1, 16'h1002);
        look("rp_new1", 16'h0201, 1'b1, 16'h2001);

        // Flush has priority over a same-cycle allocation.
        bus.flush_all = 1'b1;
        resolve(16'h0300, 1'b1, 16'h3000, 1'b0, 16'h0000);
        tick();
        look("fp_new", 16'h0300, 1'b0, 16'h0301);
        look("fp_old", 16'h0200, 1'b0, 16'h0201);
        look("fp_old2", 16'h0102, 1'b0, 16'h0103);

        // Perf counter saturation (not-taken misses change no BTB state).
        for (int i = 0; i < 20; i++) begin
            resolve(16'h0400, 1'b0, 16'h0000, 1'b1, 16'h4000);
            tick();
        end
        check("sat_cnt", 32'(bus.mispredict_count), 32'hF);
        look("sat_nostate", 16'h0400, 1'b0, 16'h0401);

        // Address wrap.
        look("wrap_look", 16'hFFFF, 1'b0, 16'h0000);
        resolve(16'hFFFF, 1'b0, 16'h0000, 1'b1, 16'h1234);
        check("wrap_redir", 32'(bus.redirect_pc), 32'h0000);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
